// File: rtl/seq_pkg.sv
// Shared definitions for the 10-bit serial link: word geometry and the
// receive-side FSM state type.
package seq_pkg;

    localparam int unsigned SEQ_WIDTH = 10;
    localparam int unsigned SEQ_CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_deserializer_sipo_shreg.sv
// Serial-in/parallel-out shift register, shifting left (MSB first), with
// enable and a clear-and-load-first-bit control for frame starts.
module sipo_shreg
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_first,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            if (load_first) begin
                q_d = {{(WIDTH-1){1'b0}}, din};
            end else begin
                q_d = {q_q[WIDTH-2:0], din};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_deserializer.sv
// Rebuilds parallel words from the MSB-first serial stream produced by the
// shift-left serializer; pulses word_valid per word and frame_err on resync.
module seq_deserializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH,
    parameter int unsigned CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             start,
    input  logic             serial_in,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             busy,
    output logic             frame_err
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             busy_q;
    logic             ferr_q;

    logic [WIDTH-1:0] shreg_q;
    logic             sh_en;
    logic             sh_load;
    logic             last_bit;

    assign last_bit = (cnt_q == CNT_W'(WIDTH-1));

    // The last bit goes straight into word, so the shift register holds then.
    always_comb begin
        sh_en   = 1'b0;
        sh_load = 1'b0;
        if (!pause) begin
            if (start) begin
                sh_en   = 1'b1;
                sh_load = 1'b1;
            end else if (state_q == SHIFT && !last_bit) begin
                sh_en = 1'b1;
            end
        end
    end

    sipo_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .en        (sh_en),
        .load_first(sh_load),
        .din       (serial_in),
        .q         (shreg_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (!pause) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (start) begin
                            ferr_q <= 1'b1;
                            cnt_q  <= CNT_W'(1);
                        end else if (last_bit) begin
                            word_q  <= {shreg_q[WIDTH-2:0], serial_in};
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_seq_deserializer.sv
// Self-checking bench for seq_deserializer: directed scenarios plus random
// traffic, compared every cycle against a bit-list reference model.
module tb_seq_deserializer;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pause = 1'b0;
    logic         start = 1'b0;
    logic         serial_in = 1'b0;
    logic [W-1:0] word;
    logic         word_valid;
    logic         busy;
    logic         frame_err;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned cyc = 0;

    // Reference model: the bits of the frame in progress, in arrival order.
    bit           m_inframe = 1'b0;
    bit           m_bits[$];
    logic [W-1:0] m_word = '0;
    logic         m_valid = 1'b0;
    logic         m_err = 1'b0;

    int unsigned  last_valid_cyc = 0;

    seq_deserializer #(
        .WIDTH(W),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .start     (start),
        .serial_in (serial_in),
        .word      (word),
        .word_valid(word_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_inframe = 1'b0;
        m_bits.delete();
        m_word  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic m_update(input logic p, input logic s, input logic b);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!p) begin
            if (s) begin
                if (m_inframe) m_err = 1'b1;
                m_bits.delete();
                m_bits.push_back(b);
                m_inframe = 1'b1;
            end else if (m_inframe) begin
                m_bits.push_back(b);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) m_word[W-1-i] = m_bits[i];
                    m_valid   = 1'b1;
                    m_inframe = 1'b0;
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        chk("word", 32'(word), 32'(m_word));
        chk("word_valid", 32'(word_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_inframe));
        chk("frame_err", 32'(frame_err), 32'(m_err));
    endtask

    task automatic step(input logic p, input logic s, input logic b);
        @(negedge clk);
        pause     = p;
        start     = s;
        serial_in = b;
        @(posedge clk);
        if (!rst) m_reset();
        else      m_update(p, s, b);
        #1;
        cyc++;
        if (word_valid === 1'b1) last_valid_cyc = cyc;
        check_all();
    endtask

    task automatic send_word(input logic [W-1:0] w, input int pause_after, input int pause_len);
        for (int i = 0; i < W; i++) begin
            step(1'b0, i == 0, w[W-1-i]);
            if (i == pause_after) begin
                for (int j = 0; j < pause_len; j++)
                    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    int unsigned v1;

    initial begin
        // Reset then idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));

        // Single frame
        send_word(10'b1011001110, -1, 0);
        chk("single_word", 32'(word), 32'h2CE);
        chk("single_valid", 32'(word_valid), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("single_valid_1cyc", 32'(word_valid), 32'd0);

        // Pause mid-frame
        send_word(10'b1011001110, 5, 4);
        chk("pause_word", 32'(word), 32'h2CE);
        chk("pause_valid", 32'(word_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0);

        // Back-to-back
        send_word(10'h3FF, -1, 0);
        chk("b2b_word0", 32'(word), 32'h3FF);
        v1 = last_valid_cyc;
        send_word(10'h001, -1, 0);
        chk("b2b_word1", 32'(word), 32'h001);
        chk("b2b_spacing", last_valid_cyc - v1, 32'd10);
        step(1'b0, 1'b0, 1'b0);

        // Resync at bit 6, then a full new frame
        for (int i = 0; i < 6; i++) step(1'b0, i == 0, 1'($urandom_range(0, 1)));
        v1 = last_valid_cyc;
        step(1'b0, 1'b1, 1'b1);
        chk("resync_err", 32'(frame_err), 32'd1);
        for (int i = 1; i < W; i++) step(1'b0, 1'b0, (i % 4 == 0 || i % 4 == 1) ? 1'b1 : 1'b0);
        chk("resync_word", 32'(word), 32'h333);
        chk("resync_valid", 32'(word_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0);

        // Start on the last bit counts as a resync
        for (int i = 0; i < W-1; i++) step(1'b0, i == 0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("lastbit_resync_err", 32'(frame_err), 32'd1);
        chk("lastbit_resync_novalid", 32'(word_valid), 32'd0);
        for (int i = 1; i < W; i++) step(1'b0, 1'b0, 1'b1);
        chk("lastbit_resync_word", 32'(word), 32'h1FF);

        // Async reset mid-frame
        for (int i = 0; i < 5; i++) step(1'b0, i == 0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_word", 32'(word), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        send_word(10'h2AA, -1, 0);
        chk("areset_after_word", 32'(word), 32'h2AA);
        chk("areset_after_valid", 32'(word_valid), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
